// File: rtl/imem_byte_loader.sv
// Byte-stream loader for the CPU instruction RAM: assembles big-endian 16-bit words,
// writes them into a small RAM read combinationally by the CPU, and holds the CPU in reset while loading.
module imem_byte_loader #(
    parameter int ADDR_W     = 4,
    parameter int WORD_COUNT = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [15:0]       fetch_instr,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   words_loaded,
    output logic              stray_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORD_COUNT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   COUNT_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV_HI = 2'd1,
        RECV_LO = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    logic [7:0]        hi_reg;
    logic [ADDR_W-1:0] waddr;
    logic [15:0]       mem [DEPTH];

    // Handshake: a byte moves on a rising edge where byte_valid & byte_ready.
    // byte_ready depends only on state, never on byte_valid.
    assign byte_ready  = (state == RECV_HI) || (state == RECV_LO);
    assign fetch_instr = mem[fetch_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            hi_reg       <= '0;
            waddr        <= '0;
            words_loaded <= '0;
            cpu_hold     <= 1'b0;
            load_done    <= 1'b0;
            stray_err    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    cpu_hold <= 1'b0;
                    if (load_start) begin
                        // A byte offered alongside load_start is dropped without flagging.
                        state        <= RECV_HI;
                        waddr        <= '0;
                        words_loaded <= '0;
                        stray_err    <= 1'b0;
                        cpu_hold     <= 1'b1;
                    end else if (byte_valid) begin
                        stray_err <= 1'b1;
                    end
                end
                RECV_HI: begin
                    cpu_hold <= 1'b1;
                    if (byte_valid) begin
                        hi_reg <= byte_in;
                        state  <= RECV_LO;
                    end
                end
                RECV_LO: begin
                    cpu_hold <= 1'b1;
                    if (byte_valid) begin
                        mem[waddr]   <= {hi_reg, byte_in};
                        waddr        <= waddr + ADDR_ONE;
                        words_loaded <= words_loaded + COUNT_ONE;
                        if (waddr == LAST_ADDR) begin
                            state     <= DONE;
                            load_done <= 1'b1;
                        end else begin
                            state <= RECV_HI;
                        end
                    end
                end
                DONE: begin
                    // cpu_hold drops with the return to IDLE, so the first fetch sees the full program.
                    cpu_hold <= 1'b0;
                    state    <= IDLE;
                    if (byte_valid) begin
                        stray_err <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cpu_hold <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_byte_loader.sv
// Directed bench for imem_byte_loader: reset, full loads, stalls, stray bytes,
// mid-session reset and ignored restart, checked with immediate assertions.
module tb_imem_byte_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [3:0]  fetch_addr;
    logic [15:0] fetch_instr;
    logic        cpu_hold;
    logic        load_done;
    logic [4:0]  words_loaded;
    logic        stray_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [15:0] prog [8] = '{16'h0123, 16'h1234, 16'h2345, 16'h3456,
                              16'h4567, 16'h5678, 16'h6789, 16'h7000};

    imem_byte_loader #(.ADDR_W(4), .WORD_COUNT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_start   (load_start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .words_loaded (words_loaded),
        .stray_err    (stray_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input bit expect_prog);
        logic [15:0] exp;
        for (int a = 0; a < 16; a++) begin
            fetch_addr = 4'(a);
            #1;
            exp = (expect_prog && a < 8) ? prog[a] : 16'h0000;
            check($sformatf("mem[%0d]", a), 32'(fetch_instr), 32'(exp));
        end
        fetch_addr = 4'd0;
    endtask

    // Full session; optional stall of stall_n cycles inside word 2, optional load_start after word 3.
    task automatic do_load(input int stall_n, input bit restart);
        bit ready_ok;
        bit hold_ok;
        bit done_early;
        ready_ok   = 1'b1;
        hold_ok    = 1'b1;
        done_early = 1'b0;
        load_start = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hFF;
        tick();
        load_start = 1'b0;
        byte_valid = 1'b0;
        check("start_stray_clear", 32'(stray_err), 32'd0);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_words", 32'(words_loaded), 32'd0);
        for (int w = 0; w < 8; w++) begin
            for (int b = 0; b < 2; b++) begin
                if (restart && w == 4 && b == 0) load_start = 1'b1;
                byte_valid = 1'b1;
                byte_in    = (b == 0) ? prog[w][15:8] : prog[w][7:0];
                if (!byte_ready) ready_ok = 1'b0;
                if (!cpu_hold) hold_ok = 1'b0;
                if (load_done) done_early = 1'b1;
                tick();
                load_start = 1'b0;
                byte_valid = 1'b0;
                if (w == 2 && b == 0) begin
                    for (int s = 0; s < stall_n; s++) begin
                        if (!byte_ready) ready_ok = 1'b0;
                        if (!cpu_hold) hold_ok = 1'b0;
                        if (load_done) done_early = 1'b1;
                        tick();
                    end
                end
            end
            if (restart && w == 3) check("restart_words4", 32'(words_loaded), 32'd4);
        end
        check("ready_during_load", 32'(ready_ok), 32'd1);
        check("hold_during_load", 32'(hold_ok), 32'd1);
        check("no_early_done", 32'(done_early), 32'd0);
        check("done_pulse", 32'(load_done), 32'd1);
        check("done_ready", 32'(byte_ready), 32'd0);
        check("done_hold", 32'(cpu_hold), 32'd1);
        check("done_words", 32'(words_loaded), 32'd8);
        tick();
        check("after_done_pulse", 32'(load_done), 32'd0);
        check("after_done_hold", 32'(cpu_hold), 32'd0);
        check("after_done_ready", 32'(byte_ready), 32'd0);
        check("after_done_words", 32'(words_loaded), 32'd8);
        tick();
        check("single_done_pulse", 32'(load_done), 32'd0);
        check("words_hold", 32'(words_loaded), 32'd8);
        check_mem(1'b1);
    endtask

    initial begin
        rst        = 1'b1;
        load_start = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        fetch_addr = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_stray", 32'(stray_err), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check_mem(1'b0);

        // Plain load, then load with a 3-cycle stall inside word 2
        do_load(0, 1'b0);
        do_load(3, 1'b0);

        // Stray byte in IDLE
        byte_valid = 1'b1;
        byte_in    = 8'hAA;
        tick();
        byte_valid = 1'b0;
        check("stray_set", 32'(stray_err), 32'd1);
        check("stray_no_hold", 32'(cpu_hold), 32'd0);
        check_mem(1'b1);
        tick();
        check("stray_sticky", 32'(stray_err), 32'd1);

        // Next load clears stray_err; load_start after word 3 is ignored
        do_load(0, 1'b1);

        // Reset after 5 bytes abandons the session
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            byte_valid = 1'b1;
            byte_in    = 8'(8'h5A + i);
            tick();
        end
        byte_valid = 1'b0;
        check("partial_words", 32'(words_loaded), 32'd2);
        check("partial_hold", 32'(cpu_hold), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_ready", 32'(byte_ready), 32'd0);
        check("midrst_words", 32'(words_loaded), 32'd0);
        check("midrst_done", 32'(load_done), 32'd0);
        check_mem(1'b0);
        tick();
        check("idle_ready", 32'(byte_ready), 32'd0);

        // Full load after the abandoned session
        do_load(0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
